pla_inverse_search: RTL
=======================

# pla_inverse_search

Sequential inverse-lookup engine for the team's 5-input, 28-output PLA decode functions. Given a target output word and a care mask, it sweeps every input code through an attached combinational evaluation function and reports the lowest code whose output matches. It also reports how many codes match. It sits beside a PLA instance: it drives the PLA inputs and reads back the PLA outputs, turning an output pattern back into its source code.

## Interface
- IN_W, 5, candidate/code width; search space is 2^IN_W codes
- OUT_W, 28, evaluation word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request a search
- start_ready  out  1  block can accept a request (IDLE only)
- target  in  OUT_W  wanted output pattern, sampled on start handshake
- mask  in  OUT_W  care bits (1 = compare), sampled on start handshake
- cand  out  IN_W  candidate code driven to the PLA inputs
- eval  in  OUT_W  PLA output for cand, combinational, same cycle
- done_valid  out  1  result available
- done_ready  in  1  consumer accepts result
- found  out  1  at least one code matched
- code  out  IN_W  lowest matching code (0 if none)
- match_count  out  IN_W+1  number of matching codes, 0..2^IN_W
- busy  out  1  high in SCAN and DONE

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: latch target_q=target, mask_q=mask; set cand=0, found=0, code=0, match_count=0; go to SCAN.
- SCAN: one candidate per cycle.
  - match = ((eval ^ target_q) & mask_q) == 0.
  - If match: match_count += 1; if found==0, set code=cand and found=1.
  - If cand==2^IN_W-1, go to DONE; otherwise cand += 1.
- No early exit: every code is evaluated, so search time is constant.
- DONE:
  - done_valid=1; found, code and match_count are held stable.
  - On done_ready: go to IDLE and set cand=0.
- Result outputs stay valid and unchanged in IDLE until the next start handshake clears them.
- Arithmetic rules:
  - cand never wraps inside a scan.
  - match_count is IN_W+1 bits, so a full match (32) does not overflow.
- mask=0: every code matches; found=1, code=0, match_count=2^IN_W.
- start_valid outside IDLE: ignored (start_ready=0); no queueing.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, start_ready=1, cand=0, done_valid=0, found=0, code=0, match_count=0, busy=0.
  - target_q and mask_q are cleared to 0.
- Reset during SCAN or DONE aborts immediately. No done_valid is produced for the aborted request.
- Latency: start accepted at edge N. SCAN occupies edges N+1..N+2^IN_W (32 cycles). done_valid is high from the cycle after edge N+32.
- The eval path is combinational within one cycle: cand -> PLA -> eval -> compare -> registers.
- done_valid and done_ready high in the same cycle completes the handshake. IDLE is entered at that edge; the earliest next start is accepted one cycle later.
- done_ready held low: DONE persists indefinitely with outputs stable.
- Back-to-back throughput: one search per 34 cycles.

## Test plan
- Stub eval = {23'b0, cand}; target=28'h0000013, mask=28'hFFFFFFF -> done_valid 33 cycles after start; found=1, code=19, match_count=1.
- Same stub; mask=28'h0000000 -> found=1, code=0, match_count=32.
- Same stub; target=28'h0000020, mask=28'h000003F -> found=0, code=0, match_count=0.
- Stub eval = {27'b0, cand[0]}; target=28'h1, mask=28'h1 -> code=1, match_count=16. Hold done_ready low for 5 cycles: outputs and done_valid stay stable. Pulse start_valid during DONE: ignored.
- Deassert rst_n at SCAN cycle 10 for 1 cycle -> outputs take reset values, no done_valid. A new start then completes normally with correct results.
- done_ready tied high with start_valid held high -> consecutive searches accepted every 34 cycles; each result is correct for its own sampled target/mask.

Source files
------------

// File: rtl/pla_inverse_search_if.sv
// Purpose: request/result handshake plus PLA drive/readback bus of the inverse-lookup engine.
// Latency: none, wiring only.
// Backpressure: start_valid/start_ready on the request side, done_valid/done_ready on the result side.
// Ports (slave = engine view):
//   start_valid/start_ready, target, mask : search request
//   cand -> PLA inputs, eval <- PLA outputs : combinational evaluation loop
//   done_valid/done_ready, found, code, match_count : search result
//   busy : engine is scanning or holding a result
interface pla_inverse_search_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 28
) ();
  logic             start_valid;
  logic             start_ready;
  logic [OUT_W-1:0] target;
  logic [OUT_W-1:0] mask;
  logic [IN_W-1:0]  cand;
  logic [OUT_W-1:0] eval;
  logic             done_valid;
  logic             done_ready;
  logic             found;
  logic [IN_W-1:0]  code;
  logic [IN_W:0]    match_count;
  logic             busy;

  // Engine side.
  modport slave (
    input  start_valid, target, mask, eval, done_ready,
    output start_ready, cand, done_valid, found, code, match_count, busy
  );

  // Requester / PLA side.
  modport master (
    output start_valid, target, mask, eval, done_ready,
    input  start_ready, cand, done_valid, found, code, match_count, busy
  );
endinterface

// File: rtl/pla_inverse_search.sv
// Purpose: sweeps every input code through an attached PLA and reports the lowest code matching target under mask, plus the match count.
// Latency: start accepted at edge N, result valid after edge N+2^IN_W; fixed, no early exit.
// Backpressure: start_ready only in IDLE; result held in DONE until done_ready, one search per 2^IN_W+2 cycles.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : pla_inverse_search_if.slave (request, PLA cand/eval loop, result)
module pla_inverse_search #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pla_inverse_search_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IN_W-1:0] CAND_LAST = '1;
  localparam logic [IN_W-1:0] CAND_ONE  = {{(IN_W-1){1'b0}}, 1'b1};
  localparam logic [IN_W:0]   CNT_ONE   = {{IN_W{1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [OUT_W-1:0] r_target;
  logic [OUT_W-1:0] r_mask;
  logic [IN_W-1:0]  r_cand;
  logic             r_found;
  logic [IN_W-1:0]  r_code;
  logic [IN_W:0]    r_count;

  logic             w_match;
  logic             w_last;
  logic             w_start_hs;
  logic             w_done_hs;

  // eval is the PLA's combinational response to r_cand in this same cycle.
  assign w_match    = ((bus.eval ^ r_target) & r_mask) == '0;
  assign w_last     = (r_cand == CAND_LAST);
  assign w_start_hs = (r_state == ST_IDLE) && bus.start_valid;
  assign w_done_hs  = (r_state == ST_DONE) && bus.done_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start_valid) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_last)          w_state_nxt = ST_DONE;
      ST_DONE: if (bus.done_ready)  w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: request capture, candidate sweep and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_mask   <= '0;
      r_cand   <= '0;
      r_found  <= 1'b0;
      r_code   <= '0;
      r_count  <= '0;
    end else begin
      if (w_start_hs) begin
        // Results from the previous search stay visible until here.
        r_target <= bus.target;
        r_mask   <= bus.mask;
        r_cand   <= '0;
        r_found  <= 1'b0;
        r_code   <= '0;
        r_count  <= '0;
      end

      if (r_state == ST_SCAN) begin
        if (w_match) begin
          // count has one spare bit so a full 2^IN_W match cannot overflow
          r_count <= r_count + CNT_ONE;
          // ascending sweep: first match seen is the lowest code
          if (!r_found) begin
            r_found <= 1'b1;
            r_code  <= r_cand;
          end
        end
        // cand parks on the last code through DONE rather than wrapping
        if (!w_last) begin
          r_cand <= r_cand + CAND_ONE;
        end
      end

      if (w_done_hs) begin
        r_cand <= '0;
      end
    end
  end

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.done_valid  = (r_state == ST_DONE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.cand        = r_cand;
  assign bus.found       = r_found;
  assign bus.code        = r_code;
  assign bus.match_count = r_count;

endmodule
